// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants for the program-building encoder: format
// codes, base opcodes, immediate range limits and the encoder FSM state type.
package rv32_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2
  } enc_state_e;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer: scatters the immediate into the bit
// positions of the selected format and flags immediates the format cannot hold.
module inst_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  // Branch and jump offsets are halfword-aligned, so bit 0 must be clear.
  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    case (fmt)
      FMT_R: begin
        word     = {funct7, rs2, rs1, funct3, rd, opcode};
        range_ok = 1'b1;
      end
      FMT_I: begin
        word     = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      FMT_S: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok = imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      end
      FMT_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok = imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
      end
      FMT_U: begin
        word     = {imm[31:12], rd, opcode};
        range_ok = (imm[11:0] == 12'h000);
      end
      FMT_J: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_ok = imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) && !imm[0];
      end
      default: begin
        word     = '0;
        range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder_writer.sv
// Encodes decoded RV32I fields into instruction words and streams the legal
// ones into IMEM at an auto-incrementing word address.
module inst_encoder_writer
  import rv32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_range,
  output logic              err_sticky
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX = '1;

  enc_state_e        state_q;
  logic              in_ready_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   cnt_q;
  logic              err_range_q;
  logic              err_sticky_q;
  logic              clr_pend_q;

  logic [2:0]        fmt_q;
  logic [6:0]        opcode_q;
  logic [4:0]        rd_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [2:0]        funct3_q;
  logic [6:0]        funct7_q;
  logic [31:0]       imm_q;

  logic [31:0]       word_d;
  logic              range_ok_d;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W:0]   cnt_d;

  inst_pack u_pack (
    .fmt      (fmt_q),
    .opcode   (opcode_q),
    .rd       (rd_q),
    .rs1      (rs1_q),
    .rs2      (rs2_q),
    .funct3   (funct3_q),
    .funct7   (funct7_q),
    .imm      (imm_q),
    .word     (word_d),
    .range_ok (range_ok_d)
  );

  assign ptr_d = ptr_q + 1'b1;
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // A clr seen while a write is stalled is remembered so the pointer reset
  // lands after that write retires at its original address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      mem_valid_q  <= 1'b0;
      ptr_q        <= BASE;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_range_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      clr_pend_q   <= 1'b0;
      fmt_q        <= '0;
      opcode_q     <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      funct3_q     <= '0;
      funct7_q     <= '0;
      imm_q        <= '0;
    end else begin
      err_range_q <= 1'b0;
      if (clr) begin
        err_sticky_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (clr) begin
            ptr_q <= BASE;
            cnt_q <= '0;
          end
          if (in_valid && in_ready_q) begin
            fmt_q      <= in_fmt;
            opcode_q   <= in_opcode;
            rd_q       <= in_rd;
            rs1_q      <= in_rs1;
            rs2_q      <= in_rs2;
            funct3_q   <= in_funct3;
            funct7_q   <= in_funct7;
            imm_q      <= in_imm;
            in_ready_q <= 1'b0;
            state_q    <= ST_ENC;
          end
        end
        ST_ENC: begin
          if (clr) begin
            ptr_q <= BASE;
            cnt_q <= '0;
          end
          if (range_ok_d) begin
            wdata_q     <= word_d;
            mem_valid_q <= 1'b1;
            state_q     <= ST_WRITE;
          end else begin
            err_range_q  <= 1'b1;
            err_sticky_q <= 1'b1;
            in_ready_q   <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (clr) begin
            clr_pend_q <= 1'b1;
          end
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            clr_pend_q  <= 1'b0;
            state_q     <= ST_IDLE;
            if (clr || clr_pend_q) begin
              ptr_q <= BASE;
              cnt_q <= '0;
            end else begin
              ptr_q <= ptr_d;
              cnt_q <= cnt_d;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = ptr_q;
  assign mem_wdata  = wdata_q;
  assign wr_count   = cnt_q;
  assign err_range  = err_range_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Scoreboard bench for inst_encoder_writer: directed encodings, range rejects,
// IMEM back-pressure, pointer wrap on a narrow instance, reset and clr mid-write.
module tb_inst_encoder_writer;
  import rv32_pkg::*;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] word;
  } expWrite_t;

  logic        clk = 1'b0;
  logic        rstN, clr, inValid, memReady;
  logic [2:0]  inFmt;
  logic [6:0]  inOpcode;
  logic [4:0]  inRd, inRs1, inRs2;
  logic [2:0]  inFunct3;
  logic [6:0]  inFunct7;
  logic [31:0] inImm;

  logic        inReady, memValid, errRange, errSticky;
  logic [9:0]  memAddr;
  logic [31:0] memWdata;
  logic [10:0] wrCount;

  logic        wInReady, wMemValid, wErrRange, wErrSticky;
  logic [1:0]  wMemAddr;
  logic [31:0] wMemWdata;
  logic [2:0]  wWrCount;

  int          vectors = 0;
  int          miscompares = 0;
  int          errSeen = 0;
  expWrite_t   scoreboard[$];
  expWrite_t   monExp;
  logic [9:0]  expAddr = '0;
  logic [31:0] seqWords[5];

  inst_encoder_writer #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rstN), .clr(clr), .in_valid(inValid), .in_ready(inReady),
    .in_fmt(inFmt), .in_opcode(inOpcode), .in_rd(inRd), .in_rs1(inRs1), .in_rs2(inRs2),
    .in_funct3(inFunct3), .in_funct7(inFunct7), .in_imm(inImm),
    .mem_valid(memValid), .mem_ready(memReady), .mem_addr(memAddr), .mem_wdata(memWdata),
    .wr_count(wrCount), .err_range(errRange), .err_sticky(errSticky)
  );

  inst_encoder_writer #(.ADDR_W(2), .BASE_ADDR(0)) dutW (
    .clk(clk), .rst_n(rstN), .clr(clr), .in_valid(inValid), .in_ready(wInReady),
    .in_fmt(inFmt), .in_opcode(inOpcode), .in_rd(inRd), .in_rs1(inRs1), .in_rs2(inRs2),
    .in_funct3(inFunct3), .in_funct7(inFunct7), .in_imm(inImm),
    .mem_valid(wMemValid), .mem_ready(memReady), .mem_addr(wMemAddr), .mem_wdata(wMemWdata),
    .wr_count(wWrCount), .err_range(wErrRange), .err_sticky(wErrSticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // The narrow instance shares every input, so it retires the same words on
  // the same cycles with the address taken modulo 4.
  always @(negedge clk) begin
    if (rstN) begin
      if (errRange) errSeen++;
      if (memValid && memReady) begin
        if (scoreboard.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write", memAddr, memWdata);
        end else begin
          monExp = scoreboard.pop_front();
          checkOutput("write_addr", 32'(memAddr), 32'(monExp.addr));
          checkOutput("write_data", memWdata, monExp.word);
          checkOutput("wrap_valid", 32'(wMemValid), 32'd1);
          checkOutput("wrap_addr", 32'(wMemAddr), 32'(monExp.addr[1:0]));
          checkOutput("wrap_data", wMemWdata, monExp.word);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opcode, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] funct3,
                               input logic [6:0] funct7, input logic [31:0] imm,
                               input logic expOk, input logic [31:0] expWord);
    int budget = 0;
    @(posedge clk); #1;
    while (!inReady && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!inReady) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
    end else begin
      inFmt = fmt; inOpcode = opcode; inRd = rd; inRs1 = rs1; inRs2 = rs2;
      inFunct3 = funct3; inFunct7 = funct7; inImm = imm;
      inValid = 1'b1;
      if (expOk) begin
        scoreboard.push_back('{addr: expAddr, word: expWord});
        expAddr = expAddr + 10'd1;
      end
      @(posedge clk); #1;
      inValid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int budget = 0;
    @(posedge clk); #1;
    while (!(scoreboard.size() == 0 && inReady && !memValid) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending writes, expected 0", scoreboard.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 10 && !memValid; i++) @(negedge clk);
    checkOutput(name, 32'(memValid), 32'd1);
  endtask

  task automatic pulseClr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; clr = 1'b0; inValid = 1'b0; memReady = 1'b1;
    inFmt = '0; inOpcode = '0; inRd = '0; inRs1 = '0; inRs2 = '0;
    inFunct3 = '0; inFunct7 = '0; inImm = '0;
    seqWords = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_mem_valid", 32'(memValid), 32'd0);
    checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_mem_wdata", memWdata, 32'd0);
    checkOutput("rst_wr_count", 32'(wrCount), 32'd0);
    checkOutput("rst_err_range", 32'(errRange), 32'd0);
    checkOutput("rst_err_sticky", 32'(errSticky), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // addi x1,x0,5 and its accept-to-valid latency
    applyStimulus(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    @(negedge clk);
    checkOutput("latency_enc_cycle", 32'(memValid), 32'd0);
    @(negedge clk);
    checkOutput("latency_write_cycle", 32'(memValid), 32'd1);
    waitIdle();
    checkOutput("count_after_addi", 32'(wrCount), 32'd1);

    // sw x2,8(x1); beq x0,x0,-4; jal x1,8; lui x5,0x12345000
    applyStimulus(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    applyStimulus(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3);
    applyStimulus(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h008000EF);
    applyStimulus(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    waitIdle();
    checkOutput("count_after_seq", 32'(wrCount), 32'd5);

    // Range rejects
    applyStimulus(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
    applyStimulus(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
    applyStimulus(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1'b0, 32'd0);
    applyStimulus(3'd7, OPC_OP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    waitIdle();
    checkOutput("err_pulse_cycles", 32'(errSeen), 32'd4);
    checkOutput("err_sticky_set", 32'(errSticky), 32'd1);
    checkOutput("reject_ptr_kept", 32'(memAddr), 32'd5);
    checkOutput("reject_count_kept", 32'(wrCount), 32'd5);

    // clr while idle
    pulseClr();
    expAddr = '0;
    checkOutput("clr_err_sticky", 32'(errSticky), 32'd0);
    checkOutput("clr_ptr", 32'(memAddr), 32'd0);
    checkOutput("clr_count", 32'(wrCount), 32'd0);

    // IMEM stalls for 5 cycles: addi x3,x0,-1
    memReady = 1'b0;
    applyStimulus(FMT_I, OPC_OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00193);
    waitValid("stall_valid_rise");
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(memValid), 32'd1);
      checkOutput("stall_addr", 32'(memAddr), 32'd0);
      checkOutput("stall_wdata", memWdata, 32'hFFF00193);
      checkOutput("stall_in_ready", 32'(inReady), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    memReady = 1'b1;
    waitIdle();
    checkOutput("count_after_stall", 32'(wrCount), 32'd1);

    // Reset in the middle of a stalled write drops it
    memReady = 1'b0;
    applyStimulus(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    waitValid("prereset_valid");
    #1 rstN = 1'b0;
    #1;
    checkOutput("reset_mid_valid", 32'(memValid), 32'd0);
    checkOutput("reset_mid_addr", 32'(memAddr), 32'd0);
    checkOutput("reset_mid_count", 32'(wrCount), 32'd0);
    checkOutput("reset_mid_in_ready", 32'(inReady), 32'd1);
    void'(scoreboard.pop_back());
    expAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    memReady = 1'b1;

    // Five writes: the 2-bit instance wraps 0,1,2,3,0
    for (int n = 0; n < 5; n++) begin
      applyStimulus(FMT_I, OPC_OP_IMM, 5'(n + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(n + 1), 1'b1, seqWords[n]);
    end
    waitIdle();
    checkOutput("wrap_count_wide", 32'(wrCount), 32'd5);
    checkOutput("wrap_count_narrow", 32'(wWrCount), 32'd5);
    checkOutput("wrap_ptr_narrow", 32'(wMemAddr), 32'd1);

    // clr during a stalled write: add x3,x1,x2 retires at addr 5, then base
    memReady = 1'b0;
    applyStimulus(FMT_R, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 1'b1, 32'h002081B3);
    waitValid("clr_write_valid");
    pulseClr();
    expAddr = '0;
    checkOutput("clr_write_hold_valid", 32'(memValid), 32'd1);
    checkOutput("clr_write_hold_addr", 32'(memAddr), 32'd5);
    memReady = 1'b1;
    waitIdle();
    checkOutput("clr_write_count", 32'(wrCount), 32'd0);
    checkOutput("clr_write_ptr", 32'(memAddr), 32'd0);
    applyStimulus(FMT_R, OPC_OP, 5'd4, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b1, 32'h40208233);
    waitIdle();
    checkOutput("post_clr_count", 32'(wrCount), 32'd1);
    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/inst_encoder_writer.md
Name: inst_encoder_writer

Overview:
- Inverse of the immediate-generation path: takes decoded RV32I fields (format, opcode, registers, funct, full 32-bit immediate) and packs them into a 32-bit instruction word.
- Range-checks the immediate against the selected format.
- Writes each legal word into instruction memory at an auto-incrementing word address over a valid/ready write port.
- Used by the test-program loader and the self-check harness to build programs in IMEM.

Parameters:
- ADDR_W, 10, IMEM word-address width; pointer wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, word address loaded into the pointer on reset and on clr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous pulse: pointer to BASE_ADDR, counters and err_sticky to 0.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6/7 illegal.
- in_opcode  in  7  placed at inst[6:0] verbatim.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R only).
- in_imm  in  32  immediate as a full signed byte-offset or value.
- mem_valid  out  1  write request to IMEM.
- mem_ready  in  1  IMEM accepts the write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- wr_count  out  ADDR_W+1  words written since reset or clr; saturates.
- err_range  out  1  one-cycle pulse when a request is rejected.
- err_sticky  out  1  set by err_range; cleared by reset or clr.

Behaviour:
- Reset values: in_ready=1, mem_valid=0, mem_addr=BASE_ADDR, mem_wdata=0, wr_count=0, err_range=0, err_sticky=0, FSM=IDLE. Reset is honoured mid-write; the pending write is dropped.
- FSM states: IDLE, ENC, WRITE.
- IDLE: in_ready=1. On in_valid&in_ready, register all fields and go to ENC.
- ENC: in_ready=0, single cycle.
  - Range-legal: register the encoded word into mem_wdata and go to WRITE.
  - Illegal: pulse err_range, set err_sticky, leave the pointer unchanged, go to IDLE.
- WRITE: mem_valid=1. mem_addr, mem_wdata and mem_valid are held stable until mem_ready.
  - On mem_valid&mem_ready: increment pointer (wraps 2^ADDR_W-1 -> 0), increment wr_count (saturating), go to IDLE.
- Throughput: minimum 3 cycles per accepted request with mem_ready tied high. First write is visible on mem_valid 2 cycles after the accept edge.
- Encoding (imm bits from in_imm):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range rules (violation = reject):
  - I/S: in_imm within [-2048, 2047].
  - B: in_imm within [-4096, 4094] and imm[0]=0.
  - J: in_imm within [-2^20, 2^20-2] and imm[0]=0.
  - U: in_imm[11:0]=0.
  - R: in_imm ignored, never rejected.
  - fmt 6/7: always rejected.
- clr:
  - In IDLE or ENC: applies immediately; a request in ENC still completes normally against the new pointer.
  - In WRITE: the current write completes at the old address, then the pointer is set to BASE_ADDR. clr takes priority over the increment; wr_count ends at 0.
- in_valid while in_ready=0 is ignored; the source must hold the request until the handshake.

Decomposition:
- Shared rv32_pkg constants: format codes FMT_R..FMT_J, the opcode constants already used by the decoder, and immediate range limits.
- One combinational sub-module, inst_pack: inputs fmt and fields; outputs word and range_ok. The FSM, pointer and counters live in the top level.

Test Plan:
- addi x1,x0,5 (fmt I, opcode 0x13, rd=1, imm=5), mem_ready=1 -> mem_wdata=0x00500093 at addr 0; wr_count=1; mem_valid on cycle accept+2.
- Sequence sw x2,8(x1); beq x0,x0,-4; jal x1,8; lui x5,0x12345000 -> words 0x0020A423, 0xFE000EE3, 0x008000EF, 0x123452B7 at addrs 1..4.
- I imm=2048; B imm=3; U imm=0x12345001; fmt=7 -> err_range pulses 4 times, err_sticky=1, no mem_valid, pointer unchanged.
- mem_ready held low 5 cycles in WRITE -> mem_valid/addr/wdata stable all 5 cycles; in_ready=0; exactly one write on release.
- ADDR_W=2, 5 legal writes -> addresses 0,1,2,3,0; wr_count=5.
- rst_n low during WRITE -> mem_valid=0 immediately, addr=BASE_ADDR; clr during WRITE -> write completes at old addr, next write at BASE_ADDR, wr_count=1 after it.
